osc_capture_ctrl: RTL and testbench
===================================

# osc_capture_ctrl

Capture controller upstream of the FPGA-to-AR9331 parallel sender. Takes the 8-bit ADC sample stream, waits for an arm command and a trigger, then writes one decimated frame of `cap_len` samples into the sample FIFO. Once the frame is complete it raises `frame_rdy` and `frame_len` toward the sender, and releases or re-arms after the sender reports completion.

## Interface
- `DATA_W`, 8, sample width
- `LEN_W`, 32, frame-length width (matches sender `len_in`)
- `DIV_W`, 16, decimation counter width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `adc_data`  in  DATA_W  ADC sample, valid when `adc_valid`
- `adc_valid`  in  1  one-cycle sample strobe
- `arm`  in  1  pulse; starts a capture from IDLE
- `continuous`  in  1  1 = re-arm automatically after `tx_done`
- `trig_mode`  in  2  0 immediate, 1 rising, 2 falling, 3 treated as immediate
- `trig_level`  in  DATA_W  trigger threshold, unsigned
- `decim`  in  DIV_W  keep 1 of every `decim`+1 samples
- `cap_len`  in  LEN_W  samples per frame; 0 treated as 1
- `fifo_full`  in  1  sample FIFO full
- `fifo_wr_en`  out  1  FIFO write strobe; reset 0
- `fifo_wr_data`  out  DATA_W  FIFO write data; reset 0
- `frame_rdy`  out  1  frame complete, level; drives sender `en`; reset 0
- `frame_len`  out  LEN_W  latched frame length; reset 0
- `tx_done`  in  1  pulse from sender when its frame transfer ends
- `overflow`  out  1  sticky: sample dropped on full FIFO; reset 0
- `state`  out  3  current state encoding, for debug; reset IDLE

## Operation
- States: IDLE, PRIME, WAIT_TRIG, CAPTURE, READY.
- **IDLE:** `arm` latches `trig_mode`, `trig_level`, `decim`, and `cap_len` (0 becomes 1). It also clears `overflow`, `wr_cnt`, and `dec_cnt`, then moves to PRIME. `arm` is ignored in every other state.
- **PRIME:** the first `adc_valid` loads `prev` with the sample and moves to WAIT_TRIG. For immediate mode, that sample is written and the block moves straight to CAPTURE (or to READY if the length is 1).
- **WAIT_TRIG:** each `adc_valid` compares `prev` against `cur`, then updates `prev`.
  - Rising trigger: `prev < level && cur >= level`.
  - Falling trigger: `prev >= level && cur < level`.
  - The triggering sample is written as sample 0 and the block enters CAPTURE with `dec_cnt`=0.
- **CAPTURE:** each `adc_valid` compares `dec_cnt` with `decim`.
  - If `dec_cnt == decim`: write the sample, increment `wr_cnt`, clear `dec_cnt`.
  - Otherwise: increment `dec_cnt`.
  - When `wr_cnt` reaches `cap_len`, the block goes to READY. `wr_cnt` counts attempted writes, including dropped ones.
- **Write rule:** a write requested while `fifo_full`=1 issues no `fifo_wr_en` and sets `overflow`. The capture continues, so frame timing is preserved.
- **READY:** `frame_rdy`=1 and `frame_len` = latched `cap_len`. On `tx_done`:
  - if `continuous`=1, go to PRIME (same latched settings, `overflow` cleared);
  - otherwise go to IDLE.
  - `frame_rdy` drops in the same transition.
- `adc_valid` in IDLE and READY is ignored; samples are discarded.
- **Arithmetic:** `wr_cnt` is LEN_W bits and `dec_cnt` is DIV_W bits, both unsigned with no wrap. `decim`=0 means every sample is kept.

## Timing
- `fifo_wr_en` and `fifo_wr_data` are registered and appear 1 cycle after the qualifying `adc_valid`. `fifo_wr_en` is high for exactly 1 cycle per write.
- `frame_rdy` rises in the same cycle as the last `fifo_wr_en` (or as the dropped last write). All frame data is therefore in the FIFO before the sender samples `en`.
- `frame_len` is stable whenever `frame_rdy`=1.
- **Simultaneous events:**
  - `adc_valid` and `tx_done` in READY: the sample is discarded.
  - `arm` and `adc_valid` in IDLE: the sample is discarded; PRIME starts on the next valid.
- **Minimum sample spacing:** back-to-back `adc_valid` every cycle is supported.
- **Reset mid-operation:** `rst_n` low forces IDLE and all outputs to their reset values asynchronously. No partial-frame recovery; FIFO flushing is the owner's responsibility.

## Structure
- Package `osc_cap_pkg` holds:
  - `cap_state_t` enum (IDLE=0, PRIME=1, WAIT_TRIG=2, CAPTURE=3, READY=4);
  - `trig_mode_t` enum (IMM, RISE, FALL, RSVD);
  - defaults for `DATA_W` and `LEN_W`.
- Sub-module `osc_trig_detect` contains the `prev` register, the level compare, and the mode select. It outputs a 1-cycle `hit` aligned with `adc_valid`.
- FSM, decimation counter, length counter, and FIFO write register live in the top module.

## Test plan
- **Immediate capture:** `trig_mode`=0, `cap_len`=4, `decim`=0, ramp 10,11,12,… one per cycle after `arm` → 4 writes of 11,12,13,14 (first valid after PRIME is 11); `frame_rdy`=1 with the 4th write; `frame_len`=4.
- **Rising trigger:** `level`=0x80, samples 0x70,0x7F,0x80,0x90,0x10, `cap_len`=3, `decim`=1 → writes 0x80,0x10,… (1 of every 2); no write before 0x80.
- **Falling trigger with a no-cross sequence:** samples staying above `level` → no write, state holds WAIT_TRIG. Then a cross below `level` → the first write is the crossing sample.
- **Overflow:** `fifo_full`=1 during the 2nd of 3 writes → 2 `fifo_wr_en` pulses, `overflow`=1, `frame_rdy` still rises after the 3rd slot, `frame_len`=3.
- **Handshake and re-arm:** in READY, pulse `tx_done` with `continuous`=1 → `frame_rdy` 0 next cycle, state PRIME, new frame captured without `arm`. With `continuous`=0 → IDLE, and further samples produce no writes.
- **Reset mid-CAPTURE:** assert `rst_n`=0 after 2 of 8 writes → `fifo_wr_en`, `frame_rdy`, `overflow`=0 immediately and state IDLE. `cap_len`=0 on the next `arm` → a single-sample frame.

Source files
------------

// File: rtl/osc_capture_ctrl_pkg.sv
// rtl/osc_capture_ctrl_pkg.sv - shared types and defaults for the oscilloscope capture controller
package osc_cap_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 32;
    localparam int DIV_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRIME     = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        READY     = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        IMM  = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        RSVD = 2'd3
    } trig_mode_t;

    // The reserved encoding behaves like immediate so a bad register value never stalls capture.
    function automatic logic is_immediate(input trig_mode_t m);
        return (m == IMM) || (m == RSVD);
    endfunction

endpackage

// File: rtl/osc_capture_ctrl_if.sv
// rtl/osc_capture_ctrl_if.sv - FIFO write port and frame handshake toward the parallel sender
interface osc_cap_if
    import osc_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_full;
    logic              frame_rdy;
    logic [LEN_W-1:0]  frame_len;
    logic              tx_done;

    modport master (
        output fifo_wr_en, fifo_wr_data, frame_rdy, frame_len,
        input  fifo_full, tx_done
    );

    modport slave (
        input  fifo_wr_en, fifo_wr_data, frame_rdy, frame_len,
        output fifo_full, tx_done
    );
endinterface

// File: rtl/osc_capture_ctrl_trig_detect.sv
// rtl/osc_capture_ctrl_trig_detect.sv - edge trigger against a level using the previous sample
module osc_trig_detect
    import osc_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic              detect_en,
    input  logic [DATA_W-1:0] cur,
    input  trig_mode_t        mode,
    input  logic [DATA_W-1:0] level,
    output logic              hit
);
    logic [DATA_W-1:0] prev;
    logic              rise;
    logic              fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else if (sample_valid) begin
            prev <= cur;
        end
    end

    assign rise = (prev <  level) && (cur >= level);
    assign fall = (prev >= level) && (cur <  level);

    always_comb begin
        hit = 1'b0;
        if (sample_valid && detect_en) begin
            case (mode)
                RISE:    hit = rise;
                FALL:    hit = fall;
                default: hit = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/osc_capture_ctrl.sv
// rtl/osc_capture_ctrl.sv - arm/trigger/decimate capture FSM feeding the sample FIFO and sender
module osc_capture_ctrl
    import osc_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              arm,
    input  logic              continuous,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DIV_W-1:0]  decim,
    input  logic [LEN_W-1:0]  cap_len,
    osc_cap_if.master         bus,
    output logic              overflow,
    output logic [2:0]        state
);
    cap_state_t        st;
    trig_mode_t        mode_q;
    logic [DATA_W-1:0] level_q;
    logic [DIV_W-1:0]  decim_q;
    logic [DIV_W-1:0]  dec_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wr_cnt;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              frame_rdy_q;
    logic              hit;
    logic              wr_req;
    logic              last_wr;

    osc_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (adc_valid && (st == PRIME || st == WAIT_TRIG)),
        .detect_en    (st == WAIT_TRIG),
        .cur          (adc_data),
        .mode         (mode_q),
        .level        (level_q),
        .hit          (hit)
    );

    // A write slot is consumed whether or not the FIFO can take it, so frame timing never slips.
    always_comb begin
        wr_req = 1'b0;
        case (st)
            PRIME:     wr_req = adc_valid && is_immediate(mode_q);
            WAIT_TRIG: wr_req = hit;
            CAPTURE:   wr_req = adc_valid && (dec_cnt == decim_q);
            default:   wr_req = 1'b0;
        endcase
    end

    assign last_wr = ((wr_cnt + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            mode_q      <= IMM;
            level_q     <= '0;
            decim_q     <= '0;
            len_q       <= '0;
            dec_cnt     <= '0;
            wr_cnt      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_rdy_q <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_req) begin
                wr_cnt  <= wr_cnt + LEN_W'(1);
                dec_cnt <= '0;
                if (bus.fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= adc_data;
                end
            end

            case (st)
                IDLE: begin
                    if (arm) begin
                        mode_q   <= trig_mode_t'(trig_mode);
                        level_q  <= trig_level;
                        decim_q  <= decim;
                        len_q    <= (cap_len == '0) ? LEN_W'(1) : cap_len;
                        overflow <= 1'b0;
                        wr_cnt   <= '0;
                        dec_cnt  <= '0;
                        st       <= PRIME;
                    end
                end
                PRIME: begin
                    if (adc_valid) begin
                        if (!wr_req) begin
                            st <= WAIT_TRIG;
                        end else if (last_wr) begin
                            st          <= READY;
                            frame_rdy_q <= 1'b1;
                        end else begin
                            st <= CAPTURE;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (hit) begin
                        if (last_wr) begin
                            st          <= READY;
                            frame_rdy_q <= 1'b1;
                        end else begin
                            st <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (adc_valid && !wr_req) begin
                        dec_cnt <= dec_cnt + DIV_W'(1);
                    end else if (wr_req && last_wr) begin
                        st          <= READY;
                        frame_rdy_q <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.tx_done) begin
                        frame_rdy_q <= 1'b0;
                        wr_cnt      <= '0;
                        dec_cnt     <= '0;
                        if (continuous) begin
                            st       <= PRIME;
                            overflow <= 1'b0;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.frame_rdy    = frame_rdy_q;
    assign bus.frame_len    = len_q;
    assign state            = st;
endmodule

// File: tb/tb_osc_capture_ctrl.sv
// tb/tb_osc_capture_ctrl.sv - self-checking bench for osc_capture_ctrl
module tb_osc_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        arm = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  trig_mode = '0;
    logic [7:0]  trig_level = '0;
    logic [15:0] decim = '0;
    logic [31:0] cap_len = '0;
    logic        overflow;
    logic [2:0]  state;

    osc_cap_if ifc ();

    osc_capture_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .arm        (arm),
        .continuous (continuous),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .cap_len    (cap_len),
        .bus        (ifc),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         exp_ovf;
    int         rise_cnt = -1;
    logic       rdy_prev = 1'b0;
    logic [7:0] smp[64];
    bit         fl[64];
    int         nsmp;

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [7:0]       lvl;
        logic [15:0]      dec;
        logic [31:0]      len;
        int               n;
        logic [0:11][7:0] s;
        int               full_idx;
        int               en;
        logic [0:5][7:0]  e;
        bit               eovf;
    } vec_t;

    vec_t vt[8];

    always @(negedge clk) begin
        if (ifc.fifo_wr_en) got.push_back(ifc.fifo_wr_data);
        if (ifc.frame_rdy && !rdy_prev) rise_cnt = got.size();
        rdy_prev = ifc.frame_rdy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic a, input logic t);
        @(posedge clk);
        #1;
        adc_valid     = v;
        adc_data      = d;
        ifc.fifo_full = f;
        arm           = a;
        ifc.tx_done   = t;
    endtask

    // Reference: pick the trigger index from the sample list, then every (dec+1)th sample.
    task automatic model(input logic [1:0] md, input logic [7:0] lv, input logic [15:0] dc,
                         input logic [31:0] ln, output bit done);
        int t;
        int l;
        int idx;
        exp_q.delete();
        exp_ovf = 0;
        t = -1;
        l = (ln == 0) ? 1 : int'(ln);
        if (md == 2'd0 || md == 2'd3) t = 0;
        else begin
            for (int i = 1; i < nsmp && t < 0; i++) begin
                if (md == 2'd1 ? (smp[i-1] < lv && smp[i] >= lv) : (smp[i-1] >= lv && smp[i] < lv))
                    t = i;
            end
        end
        done = 0;
        if (t >= 0) begin
            done = (t + (l - 1) * (int'(dc) + 1)) < nsmp;
            for (int k = 0; k < l; k++) begin
                idx = t + k * (int'(dc) + 1);
                if (idx < nsmp) begin
                    if (fl[idx]) exp_ovf = 1;
                    else exp_q.push_back(smp[idx]);
                end
            end
        end
    endtask

    task automatic scramble();
        trig_mode  = 2'($urandom);
        trig_level = 8'($urandom);
        decim      = 16'($urandom);
        cap_len    = 32'($urandom);
    endtask

    task automatic do_frame(input string nm, input logic [1:0] md, input logic [7:0] lv,
                            input logic [15:0] dc, input logic [31:0] ln,
                            input bit gaps, input bit cont, input bit do_arm);
        int k;
        got.delete();
        rise_cnt = -1;
        continuous = cont;
        if (do_arm) begin
            trig_mode = md; trig_level = lv; decim = dc; cap_len = ln;
            drive(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < nsmp; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0), 1'b0);
                    scramble();
                end
            end
            drive(1'b1, smp[i], fl[i], gaps ? 1'($urandom_range(0, 5) == 0) : 1'b0, 1'b0);
            scramble();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 20 && !ifc.frame_rdy; k++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check({nm, "_rdy"}, 32'(ifc.frame_rdy), 32'd1);
        check({nm, "_len"}, ifc.frame_len, (ln == 0) ? 32'd1 : ln);
        check({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({nm, "_nwr"}, got.size(), exp_q.size());
        check({nm, "_rdy_align"}, rise_cnt, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            check($sformatf("%s_d%0d", nm, j), (j < got.size()) ? 32'(got[j]) : 32'hDEAD, 32'(exp_q[j]));
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check({nm, "_rdy_drop"}, 32'(ifc.frame_rdy), 32'd0);
        check({nm, "_post_state"}, 32'(state), cont ? 32'd1 : 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check({nm, "_no_extra"}, got.size(), exp_q.size());
    endtask

    initial begin
        bit done;
        logic [1:0]  md;
        logic [7:0]  lv;
        logic [15:0] dc;
        logic [31:0] ln;

        ifc.fifo_full = 1'b0;
        ifc.tx_done   = 1'b0;

        vt[0] = '{"imm_ramp", 2'd0, 8'h00, 16'd0, 32'd4, 6,
                  {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  -1, 4, {8'd11, 8'd12, 8'd13, 8'd14, 8'd0, 8'd0}, 1'b0};
        vt[1] = '{"rise", 2'd1, 8'h80, 16'd1, 32'd3, 8,
                  {8'h70, 8'h7F, 8'h80, 8'h90, 8'h10, 8'h20, 8'h30, 8'h40, 8'h0, 8'h0, 8'h0, 8'h0},
                  -1, 3, {8'h80, 8'h10, 8'h30, 8'h0, 8'h0, 8'h0}, 1'b0};
        vt[2] = '{"fall", 2'd2, 8'h40, 16'd0, 32'd2, 7,
                  {8'h90, 8'h80, 8'h50, 8'h41, 8'h30, 8'h20, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  -1, 2, {8'h30, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0};
        vt[3] = '{"ovf_mid", 2'd0, 8'h00, 16'd0, 32'd3, 4,
                  {8'h01, 8'h02, 8'h03, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  1, 2, {8'h01, 8'h03, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1};
        vt[4] = '{"rsvd_dec2", 2'd3, 8'h00, 16'd2, 32'd2, 5,
                  {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  -1, 2, {8'h05, 8'h08, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0};
        vt[5] = '{"len0", 2'd0, 8'h00, 16'd0, 32'd0, 2,
                  {8'h42, 8'h43, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  -1, 1, {8'h42, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0};
        vt[6] = '{"fall_len1", 2'd2, 8'h01, 16'd0, 32'd1, 2,
                  {8'hFF, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  -1, 1, {8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0};
        vt[7] = '{"ovf_last", 2'd0, 8'h00, 16'd0, 32'd2, 2,
                  {8'h07, 8'h08, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  1, 1, {8'h07, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
        check("rst_wr_data", 32'(ifc.fifo_wr_data), 32'd0);
        check("rst_frame_rdy", 32'(ifc.frame_rdy), 32'd0);
        check("rst_frame_len", ifc.frame_len, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            nsmp = vt[v].n;
            for (int i = 0; i < 64; i++) begin
                smp[i] = (i < 12) ? vt[v].s[i] : 8'h00;
                fl[i]  = (i == vt[v].full_idx);
            end
            exp_q.delete();
            for (int i = 0; i < vt[v].en; i++) exp_q.push_back(vt[v].e[i]);
            exp_ovf = vt[v].eovf;
            do_frame(vt[v].name, vt[v].mode, vt[v].lvl, vt[v].dec, vt[v].len, 1'b0, 1'b0, 1'b1);
        end

        // Falling trigger held off by samples that stay above the level.
        got.delete();
        continuous = 1'b0;
        trig_mode = 2'd2; trig_level = 8'h40; decim = 16'd0; cap_len = 32'd1;
        drive(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("hold_state", 32'(state), 32'd2);
        check("hold_nwr", got.size(), 32'd0);
        drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("cross_nwr", got.size(), 32'd1);
        check("cross_d0", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h30);
        check("cross_rdy", 32'(ifc.frame_rdy), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("cross_idle", 32'(state), 32'd0);

        // Continuous re-arm: second frame needs no arm and starts with overflow cleared.
        nsmp = 3;
        smp[0] = 8'h21; smp[1] = 8'h22; smp[2] = 8'h23;
        fl[0] = 0; fl[1] = 1; fl[2] = 0;
        exp_q.delete(); exp_q.push_back(8'h21); exp_ovf = 1;
        do_frame("cont1", 2'd0, 8'h00, 16'd0, 32'd2, 1'b0, 1'b1, 1'b1);
        smp[0] = 8'h31; smp[1] = 8'h32; smp[2] = 8'h33;
        fl[1] = 0;
        exp_q.delete(); exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_ovf = 0;
        do_frame("cont2", 2'd0, 8'h00, 16'd0, 32'd2, 1'b0, 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("idle_no_wr", got.size(), 32'd0);
        check("idle_state", 32'(state), 32'd0);

        // Reset in the middle of an 8-sample capture.
        trig_mode = 2'd0; decim = 16'd0; cap_len = 32'd8;
        drive(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_wr_en", 32'(ifc.fifo_wr_en), 32'd1);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        check("pre_rst_state", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
        check("mid_rst_rdy", 32'(ifc.frame_rdy), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        adc_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nsmp = 2;
        smp[0] = 8'h77; smp[1] = 8'h78; fl[0] = 0; fl[1] = 0;
        exp_q.delete(); exp_q.push_back(8'h77); exp_ovf = 0;
        do_frame("post_rst_len0", 2'd0, 8'h00, 16'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 30; r++) begin
            do begin
                md = 2'($urandom);
                lv = 8'($urandom_range(40, 200));
                dc = 16'($urandom_range(0, 3));
                ln = 32'($urandom_range(0, 5));
                nsmp = 40;
                for (int i = 0; i < nsmp; i++) begin
                    smp[i] = 8'($urandom);
                    fl[i]  = ($urandom_range(0, 7) == 0);
                end
                model(md, lv, dc, ln, done);
            end while (!done);
            do_frame($sformatf("rnd%0d", r), md, lv, dc, ln, 1'b1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
